alu_seq: RTL and testbench

Sequential ALU responder on the ready/valid command interface driven by the ALU test bench and any future command initiator. It accepts one operand pair and opcode while `o_ready` is high, computes ADD/SUB in one execute cycle and MUL by iterative shift-add, and returns the result with a single-cycle `o_valid` pulse. `o_ready` and `o_valid` are edge-meaningful: the initiator reacts to their rising edges. Each output must therefore fall between transactions.

---
 rtl/alu_seq.sv | 144 ++++++++++++++
 tb/tb_alu_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU responder: ready/valid command interface, single-cycle ADD/SUB,
// iterative shift-add MUL with fixed WIDTH-step latency. All outputs are registered.
module alu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [1:0]       i_cmd,
    output logic [WIDTH-1:0] o_result,
    output logic             o_valid,
    output logic             o_ready
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] OpNop = 2'b00;
    localparam logic [1:0] OpAdd = 2'b01;
    localparam logic [1:0] OpSub = 2'b10;
    localparam logic [1:0] OpMul = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       cmd_q, cmd_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;   // operand A; shifted left during MUL
    logic [WIDTH-1:0] mplier_q, mplier_d; // operand B; shifted right during MUL
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             valid_q, valid_d;
    logic             ready_q, ready_d;

    logic [WIDTH-1:0] acc_step;

    // One shift-add step: accumulate the multiplicand when the multiplier LSB is set.
    always_comb begin
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    // Next-state logic for the IDLE/EXEC/DONE sequencer and its datapath.
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        valid_d  = 1'b0;
        ready_d  = ready_q;

        case (state_q)
            StIdle: begin
                // ready_q is low only in the first cycle after reset, so no command
                // is accepted there even though the FSM is already idle.
                ready_d = 1'b1;
                if (ready_q && (i_cmd != OpNop)) begin
                    cmd_d    = i_cmd;
                    mcand_d  = i_a;
                    mplier_d = i_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    ready_d  = 1'b0;
                    state_d  = StExec;
                end
            end
            StExec: begin
                case (cmd_q)
                    OpAdd: begin
                        result_d = mcand_q + mplier_q;
                        valid_d  = 1'b1;
                        state_d  = StDone;
                    end
                    OpSub: begin
                        result_d = mcand_q - mplier_q;
                        valid_d  = 1'b1;
                        state_d  = StDone;
                    end
                    OpMul: begin
                        acc_d    = acc_step;
                        mcand_d  = mcand_q << 1;
                        mplier_d = mplier_q >> 1;
                        // No early exit: always WIDTH steps for constant latency.
                        if (cnt_q == CntW'(WIDTH - 1)) begin
                            result_d = acc_step;
                            valid_d  = 1'b1;
                            state_d  = StDone;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        // NOP is never captured; recover to idle if it ever is.
                        ready_d = 1'b1;
                        state_d = StIdle;
                    end
                endcase
            end
            StDone: begin
                ready_d = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous active-high reset clearing everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cmd_q    <= OpNop;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
        end
    end

    assign o_result = result_q;
    assign o_valid  = valid_q;
    assign o_ready  = ready_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized scoreboard bench for alu_seq: driver pushes expected results and
// valid cycles, an independent monitor pops and compares on every o_valid.
module tb_alu_seq;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] i_a = '0;
    logic [W-1:0] i_b = '0;
    logic [1:0]   i_cmd = 2'b00;
    logic [W-1:0] o_result;
    logic         o_valid;
    logic         o_ready;

    alu_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_cmd    (i_cmd),
        .o_result (o_result),
        .o_valid  (o_valid),
        .o_ready  (o_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    logic rst_seen = 1'b1;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= reset;
    end

    typedef struct {
        logic [W-1:0] res;
        int           cyc;
    } exp_t;

    exp_t         sb_q[$];
    int           checks = 0;
    int           passes = 0;
    logic [W-1:0] held = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic finish_run();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    endtask

    // Reference model from the arithmetic rules, not the shift-add hardware.
    function automatic logic [W-1:0] model(input logic [1:0] c, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [63:0] p;
        case (c)
            2'b01:   return a + b;
            2'b10:   return a - b;
            2'b11: begin
                p = 64'(a) * 64'(b);
                return p[W-1:0];
            end
            default: return '0;
        endcase
    endfunction

    // Wait (bounded) for o_ready; checks the cycle in which it rises.
    task automatic wait_ready(input bit toggle, input int exp_cyc);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (o_ready) begin
                i_cmd = 2'b00;
                chk("ready_return_cycle", 64'(cyc), 64'(exp_cyc));
                return;
            end
            if (toggle) begin
                i_a   = $urandom;
                i_b   = $urandom;
                i_cmd = 2'($urandom);
            end else begin
                i_cmd = 2'b00;
            end
        end
        chk("ready_timeout", 64'(0), 64'(1));
        finish_run();
    endtask

    // Must be called at a negedge where o_ready is high.
    task automatic issue(input logic [1:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit toggle);
        int k;
        int lat;
        exp_t e;
        k     = cyc;
        lat   = (c == 2'b11) ? W + 1 : 2;
        i_cmd = c;
        i_a   = a;
        i_b   = b;
        e.res = model(c, a, b);
        e.cyc = k + lat;
        sb_q.push_back(e);
        wait_ready(toggle, k + lat + 1);
    endtask

    // Monitor: overlap, reset values, scoreboard compare on valid, result hold.
    initial begin
        exp_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("ready_valid_overlap", 64'(o_ready & o_valid), 64'(0));
            if (rst_seen) begin
                held = '0;
                chk("reset_outputs", {31'(0), o_ready, o_valid, o_result}, 64'(0));
            end else if (o_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_valid", 64'(1), 64'(0));
                end else begin
                    e = sb_q.pop_front();
                    chk("result", 64'(o_result), 64'(e.res));
                    chk("valid_cycle", 64'(cyc), 64'(e.cyc));
                    held = e.res;
                end
            end else begin
                chk("result_hold", 64'(o_result), 64'(held));
            end
        end
    end

    // Driver / stimulus.
    initial begin
        int k;
        logic [1:0] c;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 64'(o_ready), 64'(1));

        issue(2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        issue(2'b10, 32'd5, 32'd7, 1'b0);
        issue(2'b11, 32'd3, 32'd7, 1'b1);
        issue(2'b11, 32'h0001_0000, 32'h0001_0000, 1'b0);
        issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

        // Stall with NOP: ready must stay high, monitor catches any stray valid.
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk("stall_ready", 64'(o_ready), 64'(1));
        end

        // Abort a MUL with reset in cycle k+10; nothing is pushed for it.
        k     = cyc;
        i_cmd = 2'b11;
        i_a   = 32'h1234_5678;
        i_b   = 32'h0000_0321;
        while (cyc < k + 10) begin
            @(negedge clk);
            i_cmd = 2'($urandom);
            i_a   = $urandom;
            i_b   = $urandom;
            chk("busy_not_ready", 64'(o_ready), 64'(0));
        end
        reset = 1'b1;
        i_cmd = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_abort", 64'(o_ready), 64'(1));

        for (int n = 0; n < 32; n++) begin
            issue(2'b01, $urandom, $urandom, 1'b0);
        end
        for (int n = 0; n < 16; n++) begin
            c = 2'($urandom_range(1, 3));
            issue(c, $urandom, $urandom, n[0]);
        end

        for (int n = 0; n < 100 && sb_q.size() != 0; n++) @(negedge clk);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'(0));
        finish_run();
    end

endmodule
